// File: rtl/mdu_seq.sv
// Iterative RV32M multiply/divide sequencer beside the EX-stage ALU.
// Shift-add multiply and restoring divide on operand magnitudes, one bit per cycle.
module mdu_seq #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    input  logic            flush,
    output logic            stall,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);
    localparam int unsigned CW = $clog2(XLEN);

    typedef enum logic [2:0] {IDLE, PREP, CALC, FIX, DONE} state_t;
    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } op_t;

    state_t              state;
    op_t                 op;
    logic [XLEN-1:0]     opa, opb, mcand;
    logic [2*XLEN-1:0]   acc;
    logic [CW-1:0]       count;
    logic                sign_q, sign_r;

    logic                is_div, is_rem, a_signed, b_signed, a_neg, b_neg;
    logic                div_zero, div_ovf, div_ge;
    logic [XLEN-1:0]     a_mag, b_mag, div_diff, quot_fix, rem_fix, fix_res;
    logic [XLEN:0]       mul_sum, rem_sh;
    logic [2*XLEN-1:0]   mul_next, div_next, prod;

    always_comb begin
        is_div   = op[2];
        is_rem   = op[2] & op[1];
        a_signed = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
        b_signed = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
        a_neg    = a_signed & opa[XLEN-1];
        b_neg    = b_signed & opb[XLEN-1];
        a_mag    = a_neg ? ('0 - opa) : opa;
        b_mag    = b_neg ? ('0 - opb) : opb;
        div_zero = (opb == '0);
        div_ovf  = ((op == OP_DIV) || (op == OP_REM)) &&
                   (opa == {1'b1, {(XLEN-1){1'b0}}}) && (opb == '1);

        // Multiplier sits in the low half and is consumed as the product shifts in.
        mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, mcand};
        mul_next = acc[0] ? {mul_sum, acc[XLEN-1:1]} : {1'b0, acc[2*XLEN-1:1]};

        // {rem, quot} shift left; the bit shifted out of rem joins a 33-bit compare.
        rem_sh   = acc[2*XLEN-1:XLEN-1];
        div_ge   = rem_sh >= {1'b0, mcand};
        div_diff = rem_sh[XLEN-1:0] - mcand;
        div_next = div_ge ? {div_diff, acc[XLEN-2:0], 1'b1}
                          : {rem_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0};

        prod     = sign_q ? ('0 - acc) : acc;
        quot_fix = sign_q ? ('0 - acc[XLEN-1:0]) : acc[XLEN-1:0];
        rem_fix  = sign_r ? ('0 - acc[2*XLEN-1:XLEN]) : acc[2*XLEN-1:XLEN];
        unique case (op)
            OP_MUL:                       fix_res = prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fix_res = prod[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              fix_res = quot_fix;
            default:                      fix_res = rem_fix;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            op     <= OP_MUL;
            opa    <= '0;
            opb    <= '0;
            mcand  <= '0;
            acc    <= '0;
            count  <= '0;
            sign_q <= 1'b0;
            sign_r <= 1'b0;
            result <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start && !flush) begin
                        op    <= op_t'(funct3);
                        opa   <= A;
                        opb   <= B;
                        state <= PREP;
                    end
                end
                PREP: begin
                    if (flush) begin
                        state <= IDLE;
                    end else begin
                        sign_q <= a_neg ^ b_neg;
                        sign_r <= a_neg;
                        count  <= CW'(XLEN-1);
                        if (is_div && div_zero) begin
                            result <= is_rem ? opa : '1;
                            done   <= 1'b1;
                            state  <= DONE;
                        end else if (div_ovf) begin
                            result <= is_rem ? '0 : opa;
                            done   <= 1'b1;
                            state  <= DONE;
                        end else begin
                            acc   <= is_div ? {{XLEN{1'b0}}, a_mag} : {{XLEN{1'b0}}, b_mag};
                            mcand <= is_div ? b_mag : a_mag;
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (flush) begin
                        state <= IDLE;
                    end else begin
                        acc   <= is_div ? div_next : mul_next;
                        count <= count - 1'b1;
                        if (count == '0)
                            state <= FIX;
                    end
                end
                FIX: begin
                    if (flush) begin
                        state <= IDLE;
                    end else begin
                        result <= fix_res;
                        done   <= 1'b1;
                        state  <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy  = (state != IDLE);
    assign stall = start || (state == PREP) || (state == CALC) || (state == FIX);
endmodule
